// File: rtl/reminder_pkg.sv
// Shared types and default sizing for the reminder stretcher.
// Channel state is a single bit, where ACTIVE means the reminder is being stretched.
package reminder_pkg;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_CNT_W     = 27;
    localparam int DEF_RETRIGGER = 0;

    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_ACTIVE = 1'b1
    } ch_state_t;

endpackage

// File: rtl/reminder_stretch_ch.sv
// One reminder channel: it detects the rising edge, runs the IDLE/ACTIVE hold FSM with
// an up-counter, and keeps the sticky missed flag.
module reminder_stretch_ch
    import reminder_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RETRIGGER = DEF_RETRIGGER
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             reminder,
    input  logic             ack,
    input  logic [CNT_W-1:0] duration,
    output logic             missed,
    output ch_state_t        state_o,
    output logic             active_nxt_o
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             rem_q, rem_d;
    logic             armed_q, armed_d;
    logic             missed_q, missed_d;
    logic             rise;
    logic             dur_ok;

    // armed stays low after reset until reminder is first seen low, so a level that is
    // already high at reset release is not taken as an edge.
    assign rise    = reminder & ~rem_q & armed_q;
    assign dur_ok  = (duration != '0);
    assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        rem_d    = reminder;
        armed_d  = armed_q | ~reminder;
        state_d  = state_q;
        cnt_d    = cnt_q;
        dur_d    = dur_q;
        missed_d = missed_q;
        case (state_q)
            CH_IDLE: begin
                if (ack) begin
                    missed_d = 1'b0;
                end
                if (rise && dur_ok) begin
                    state_d = CH_ACTIVE;
                    dur_d   = duration;
                    cnt_d   = '0;
                end
            end
            CH_ACTIVE: begin
                if (ack) begin
                    state_d  = CH_IDLE;
                    missed_d = 1'b0;
                    cnt_d    = '0;
                end else if ((RETRIGGER != 0) && rise && dur_ok) begin
                    dur_d = duration;
                    cnt_d = '0;
                end else if (cnt_inc == dur_q) begin
                    // cnt_q never exceeds dur_q - 1, so the increment cannot wrap.
                    state_d  = CH_IDLE;
                    missed_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= CH_IDLE;
            cnt_q    <= '0;
            dur_q    <= '0;
            rem_q    <= 1'b0;
            armed_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dur_q    <= dur_d;
            rem_q    <= rem_d;
            armed_q  <= armed_d;
            missed_q <= missed_d;
        end
    end

    assign missed       = missed_q;
    assign state_o      = state_q;
    assign active_nxt_o = (state_d == CH_ACTIVE);

endmodule

// File: rtl/reminder_stretcher.sv
// Reminder stretcher top: NUM_CH independent stretch channels and a registered any_active
// summary that tracks the extended bits in the same cycle.
module reminder_stretcher
    import reminder_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RETRIGGER = DEF_RETRIGGER
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] reminder,
    input  logic [NUM_CH-1:0] ack,
    input  logic [CNT_W-1:0]  duration,
    output logic [NUM_CH-1:0] extended,
    output logic [NUM_CH-1:0] missed,
    output logic              any_active
);

    ch_state_t         ch_state [NUM_CH];
    logic [NUM_CH-1:0] active_nxt;
    logic              any_active_d, any_active_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        reminder_stretch_ch #(
            .CNT_W     (CNT_W),
            .RETRIGGER (RETRIGGER)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .reminder     (reminder[i]),
            .ack          (ack[i]),
            .duration     (duration),
            .missed       (missed[i]),
            .state_o      (ch_state[i]),
            .active_nxt_o (active_nxt[i])
        );
        assign extended[i] = (ch_state[i] == CH_ACTIVE);
    end

    // The OR is taken over the next-state bits, so the registered copy lines up with extended.
    always_comb begin
        any_active_d = |active_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_active_q <= 1'b0;
        end else begin
            any_active_q <= any_active_d;
        end
    end

    assign any_active = any_active_q;

endmodule

// File: tb/tb_reminder_stretcher.sv
// Bench for reminder_stretcher: one-shot and retriggerable instances share the same stimulus and
// are compared every cycle against a countdown model. Directed traces pin the model to fixed values.
module tb_reminder_stretcher;

    localparam int NCH = 2;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NCH-1:0] reminder, ack;
    logic [CW-1:0]  duration;
    logic [NCH-1:0] ext0, miss0, ext1, miss1;
    logic           any0, any1;

    always #5 clk = ~clk;

    reminder_stretcher #(.NUM_CH(NCH), .CNT_W(CW), .RETRIGGER(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .reminder(reminder), .ack(ack), .duration(duration),
        .extended(ext0), .missed(miss0), .any_active(any0)
    );

    reminder_stretcher #(.NUM_CH(NCH), .CNT_W(CW), .RETRIGGER(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .reminder(reminder), .ack(ack), .duration(duration),
        .extended(ext1), .missed(miss1), .any_active(any1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each channel/mode holds the number of remaining high cycles (0 = idle).
    int rem_m  [2][NCH];
    bit miss_m [2][NCH];
    bit prev_m [NCH];
    bit armed_m[NCH];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                prev_m[c]  = 1'b0;
                armed_m[c] = 1'b0;
                for (int m = 0; m < 2; m++) begin
                    rem_m[m][c]  = 0;
                    miss_m[m][c] = 1'b0;
                end
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                bit rise;
                rise = reminder[c] && !prev_m[c] && armed_m[c];
                for (int m = 0; m < 2; m++) begin
                    if (rem_m[m][c] > 0) begin
                        if (ack[c]) begin
                            rem_m[m][c]  = 0;
                            miss_m[m][c] = 1'b0;
                        end else if (m == 1 && rise && duration != 0) begin
                            rem_m[m][c] = int'(duration);
                        end else begin
                            rem_m[m][c] = rem_m[m][c] - 1;
                            if (rem_m[m][c] == 0) miss_m[m][c] = 1'b1;
                        end
                    end else begin
                        if (ack[c]) miss_m[m][c] = 1'b0;
                        if (rise && duration != 0) rem_m[m][c] = int'(duration);
                    end
                end
                prev_m[c]  = reminder[c];
                armed_m[c] = armed_m[c] | !reminder[c];
            end
        end
    end

    function automatic logic [31:0] mdl_ext(input int m);
        logic [31:0] r = '0;
        for (int c = 0; c < NCH; c++) r[c] = (rem_m[m][c] > 0);
        return r;
    endfunction

    function automatic logic [31:0] mdl_miss(input int m);
        logic [31:0] r = '0;
        for (int c = 0; c < NCH; c++) r[c] = miss_m[m][c];
        return r;
    endfunction

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        check("ext_oneshot",  32'(ext0),  mdl_ext(0));
        check("miss_oneshot", 32'(miss0), mdl_miss(0));
        check("any_oneshot",  32'(any0),  32'(|mdl_ext(0)));
        check("ext_retrig",   32'(ext1),  mdl_ext(1));
        check("miss_retrig",  32'(miss1), mdl_miss(1));
        check("any_retrig",   32'(any1),  32'(|mdl_ext(1)));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cleanup();
        reminder = '0;
        ack      = '1;
        step();
        ack = '0;
        step();
        step();
    endtask

    // Channel-0 traces: bit k holds the value k clocks after the clock that samples index 0.
    logic [31:0] tr_ext [2], tr_miss [2], tm_ext [2], tm_miss [2];
    logic [31:0] tr_ch1;

    task automatic run_sched(input logic [31:0] rb, input logic [31:0] ab, input int len,
                             input int d0, input int d_alt, input int alt_at);
        for (int m = 0; m < 2; m++) begin
            tr_ext[m] = '0; tr_miss[m] = '0; tm_ext[m] = '0; tm_miss[m] = '0;
        end
        tr_ch1 = '0;
        for (int k = 0; k < len; k++) begin
            reminder[0] = rb[k];
            ack[0]      = ab[k];
            duration    = (alt_at >= 0 && k >= alt_at) ? CW'(d_alt) : CW'(d0);
            step();
            tr_ext[0][k+1]  = ext0[0];
            tr_miss[0][k+1] = miss0[0];
            tr_ext[1][k+1]  = ext1[0];
            tr_miss[1][k+1] = miss1[0];
            tm_ext[0][k+1]  = (rem_m[0][0] > 0);
            tm_miss[0][k+1] = miss_m[0][0];
            tm_ext[1][k+1]  = (rem_m[1][0] > 0);
            tm_miss[1][k+1] = miss_m[1][0];
            tr_ch1[k+1]     = ext0[1] | ext1[1] | miss0[1] | miss1[1];
        end
        reminder[0] = 1'b0;
        ack[0]      = 1'b0;
    endtask

    task automatic pin(input string name, input int m, input logic [31:0] e_ext,
                       input logic [31:0] e_miss);
        check({name, "_mdl_ext"},  tm_ext[m],  e_ext);
        check({name, "_mdl_miss"}, tm_miss[m], e_miss);
        check({name, "_dut_ext"},  tr_ext[m],  e_ext);
        check({name, "_dut_miss"}, tr_miss[m], e_miss);
    endtask

    initial begin
        reset_n  = 1'b0;
        reminder = '0;
        ack      = '0;
        duration = '0;
        step();
        step();
        check("rst_ext0", 32'(ext0), 32'h0);
        check("rst_miss0", 32'(miss0), 32'h0);
        check("rst_any1", 32'(any1), 32'h0);
        reset_n = 1'b1;
        step();
        step();

        // One-shot expiry; a duration change mid-hold must not matter.
        run_sched(32'h1, 32'h0, 10, 5, 1, 2);
        pin("expiry", 0, 32'h3E, 32'h7C0);
        check("expiry_ch1", tr_ch1, 32'h0);
        cleanup();

        // Early ack at relative clock 2.
        run_sched(32'h1, 32'h4, 8, 5, 0, -1);
        pin("early_ack", 0, 32'h6, 32'h0);
        cleanup();

        // Second edge at relative clock 3: restarts in retrigger mode, ignored in one-shot mode.
        run_sched(32'h9, 32'h0, 12, 5, 0, -1);
        pin("retrig_r1", 1, 32'h1FE, 32'h1E00);
        pin("retrig_r0", 0, 32'h3E, 32'h1FC0);
        cleanup();

        // Zero duration ignored.
        run_sched(32'h1, 32'h0, 6, 0, 0, -1);
        pin("zero_dur", 0, 32'h0, 32'h0);
        cleanup();

        // Level held for 20 cycles gives a single hold.
        run_sched(32'hFFFFF, 32'h0, 24, 3, 0, -1);
        pin("held_r0", 0, 32'hE, 32'h1FFFFF0);
        pin("held_r1", 1, 32'hE, 32'h1FFFFF0);
        cleanup();

        // Ack and edge together while active: ack wins in both modes.
        run_sched(32'h5, 32'h4, 8, 5, 0, -1);
        pin("coll_act_r0", 0, 32'h6, 32'h0);
        pin("coll_act_r1", 1, 32'h6, 32'h0);
        cleanup();

        // Expiry leaves missed set; then edge and ack together while idle.
        run_sched(32'h21, 32'h20, 10, 2, 0, -1);
        pin("coll_idle", 0, 32'hC6, 32'h738);
        cleanup();

        // Expiry and ack on the same clock count as an ack.
        run_sched(32'h1, 32'h4, 6, 2, 0, -1);
        pin("exp_ack", 0, 32'h6, 32'h0);
        cleanup();

        // Reset in the middle of a hold; ch1 is held high across the release.
        duration    = CW'(5);
        reminder[0] = 1'b1;
        step();
        reminder[0] = 1'b0;
        step();
        step();
        check("pre_rst_ext", 32'(ext0[0]), 32'h1);
        reminder[1] = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_ext0", 32'(ext0), 32'h0);
        check("rst_mid_any0", 32'(any0), 32'h0);
        check("rst_mid_ext1", 32'(ext1), 32'h0);
        check("rst_mid_miss0", 32'(miss0), 32'h0);
        step();
        step();
        reset_n = 1'b1;
        repeat (8) step();
        check("post_rst_miss", 32'(miss0[0]), 32'h0);
        check("post_rst_held", 32'(ext0[1] | ext1[1]), 32'h0);
        reminder[1] = 1'b0;
        step();
        reminder[1] = 1'b1;
        step();
        check("rearm_ext", 32'(ext0[1]), 32'h1);
        cleanup();

        // Random traffic on both channels.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) == 0) reminder[c] = ~reminder[c];
                ack[c] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 7) == 0) duration = CW'($urandom_range(0, 7));
            if ($urandom_range(0, 599) == 0) begin
                reset_n = 1'b0;
                step();
                reset_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reminder_stretcher.md
REMINDER_STRETCHER -- requirements
Module: reminder_stretcher

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent reminder channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 27, giving the hold-counter width in bits.
REQ-003 The block SHALL have parameter RETRIGGER, default 0, where 0 means one-shot and 1 means retriggerable.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port reminder, input, NUM_CH bits: per-channel reminder request, level, synchronous to clk.
REQ-007 The block SHALL have port ack, input, NUM_CH bits: per-channel user dismiss, level, synchronous to clk.
REQ-008 The block SHALL have port duration, input, CNT_W bits: hold length in clk cycles, shared by all channels.
REQ-009 The block SHALL have port extended, output, NUM_CH bits: per-channel stretched reminder, registered.
REQ-010 The block SHALL have port missed, output, NUM_CH bits: per-channel sticky flag meaning the reminder expired unacknowledged.
REQ-011 The block SHALL have port any_active, output, 1 bit: OR of all extended bits, registered.

Function
REQ-012 Each channel SHALL detect a rising edge of reminder[i] against a registered copy of the previous sample; a level held high SHALL count as one edge.
REQ-013 Each channel SHALL implement a two-state FSM, IDLE and ACTIVE; extended[i] SHALL be 1 exactly when the state is ACTIVE.
REQ-014 On an edge in IDLE with duration != 0, the channel SHALL latch duration, clear its counter, and enter ACTIVE on the next clock.
REQ-015 If the edge is sampled at clock n, extended[i] SHALL be high from clock n+1 for exactly D cycles, where D is the latched duration.
REQ-016 An edge with duration == 0 SHALL be ignored, and the channel SHALL remain IDLE.
REQ-017 In ACTIVE the counter SHALL increment by 1 per cycle, and SHALL return the channel to IDLE when count+1 equals the latched D.
REQ-018 The counter SHALL never wrap.
REQ-019 A change on duration while ACTIVE SHALL not affect the running hold.
REQ-020 On expiry to IDLE without ack, the channel SHALL set missed[i] on the same clock that extended[i] falls.
REQ-021 Asserting ack[i] in ACTIVE SHALL force IDLE on the next clock and SHALL clear missed[i]; missed[i] SHALL not be set by that exit.
REQ-022 Asserting ack[i] in IDLE SHALL clear missed[i] on the next clock.
REQ-023 With RETRIGGER=0, an edge in ACTIVE SHALL be ignored.
REQ-024 With RETRIGGER=1, an edge in ACTIVE SHALL relatch duration and clear the counter, restarting a full D-cycle hold.
REQ-025 For simultaneous ack and edge in ACTIVE, ack SHALL win and the channel SHALL go IDLE; the edge SHALL be discarded.
REQ-026 For simultaneous ack and edge in IDLE, the channel SHALL enter ACTIVE and missed[i] SHALL clear.
REQ-027 Expiry and ack on the same cycle SHALL be treated as an ack: IDLE, missed[i] cleared.
REQ-028 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-029 any_active SHALL equal the OR of the extended bits of the same cycle.

Reset
REQ-030 While reset_n=0, extended, missed, any_active, all counters, latched durations and edge registers SHALL be 0, and every FSM SHALL be IDLE.
REQ-031 Reset asserted mid-hold SHALL drop extended immediately (asynchronously) and SHALL not set missed.
REQ-032 After reset deassertion, a reminder already high SHALL not produce an edge until it first goes low.

Structure
REQ-033 A shared package reminder_pkg SHALL hold the ch_state_t enum (CH_IDLE, CH_ACTIVE) and the default constants for NUM_CH, CNT_W and RETRIGGER.
REQ-034 One sub-module, reminder_stretch_ch, SHALL implement a single channel (edge detect, FSM, counter, missed flag); the top SHALL generate NUM_CH instances and the any_active register.

Verification
REQ-035 The bench SHALL cover one-shot expiry: NUM_CH=2, CNT_W=8, duration=5, 1-cycle pulse on ch0 at clk 10 -> extended[0] high clks 11-15, missed[0] set at 16, ch1 unaffected.
REQ-036 The bench SHALL cover early ack: duration=5, edge at clk 10, ack[0] at clk 12 -> extended[0] low from clk 13, missed[0] stays 0.
REQ-037 The bench SHALL cover retrigger: RETRIGGER=1, duration=5, edges at clk 10 and clk 13 -> extended[0] high clks 11-18; with RETRIGGER=0 the same stimulus gives high clks 11-15.
REQ-038 The bench SHALL cover the zero-duration and held-level cases: duration=0 with an edge -> no assertion; reminder held high for 20 cycles with duration=3 -> a single 3-cycle hold.
REQ-039 The bench SHALL cover collisions: ack and edge on the same cycle in ACTIVE -> IDLE next clock; in IDLE -> ACTIVE and missed cleared.
REQ-040 The bench SHALL cover reset mid-hold: reset_n low at clk 13 of a 5-cycle hold -> all outputs 0 at once and missed[0]=0 after release.
